// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions for the client arbiter and its beat counters.
//   - A and D channel opcode encodings
//   - lock FSM state type
//   - tl_num_beats(): beats in a message, given opcode, size and log2 beat bytes
package tl_ul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ARITH       = 3'd2;
  localparam logic [2:0] LOGICAL     = 3'd3;
  localparam logic [2:0] GET         = 3'd4;

  // D-channel opcodes
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  // Wide enough for 1 << 7 beats (size 7 with one-byte beats)
  localparam int BEAT_CNT_W = 8;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // A and D opcode spaces overlap numerically, so the caller states which
  // channel the opcode belongs to. Only data-carrying messages span beats.
  function automatic logic [BEAT_CNT_W-1:0] tl_num_beats(
    input logic [2:0] opcode,
    input logic [2:0] size,
    input int         beat_lg,
    input logic       d_chan
  );
    logic has_data;
    has_data = d_chan ? (opcode == ACK_DATA) : (opcode <= LOGICAL);
    if (has_data && (int'(size) > beat_lg))
      return BEAT_CNT_W'(1) << (int'(size) - beat_lg);
    return BEAT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/tl_ul_client_arbiter_if.sv
// One TileLink-UL link (A request + D response channel), 32-bit data.
//   SW      : source id width of this link
//   master  : the side that issues A requests and accepts D responses
//   slave   : the side that accepts A requests and returns D responses
interface tl_ul_client_arbiter_if #(
  parameter int SW = 2
);
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [2:0]    a_param;
  logic [2:0]    a_size;
  logic [SW-1:0] a_source;
  logic [31:0]   a_address;
  logic [3:0]    a_mask;
  logic [31:0]   a_data;
  logic          a_corrupt;

  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [2:0]    d_size;
  logic [SW-1:0] d_source;
  logic          d_denied;
  logic [31:0]   d_data;
  logic          d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address,
           a_mask, a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_denied,
           d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
           a_mask, a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_denied,
           d_data, d_corrupt
  );
endinterface

// File: rtl/tl_beat_counter.sv
// Tracks position inside a multi-beat TileLink message on one channel.
//   clock, reset : clock and asynchronous active-low reset
//   i_fire       : a beat is transferred this cycle
//   i_opcode     : opcode of the current beat (only looked at on first beats)
//   i_size       : size of the current beat (only looked at on first beats)
//   o_first      : the current beat is the first of its message
//   o_last       : the current beat is the last of its message
module tl_beat_counter
  import tl_ul_pkg::*;
#(
  parameter int   BEAT_LG = 2,
  parameter logic D_CHAN  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_fire,
  input  logic [2:0] i_opcode,
  input  logic [2:0] i_size,
  output logic       o_first,
  output logic       o_last
);

  // Beats still owed by the message in progress; zero means the next beat
  // starts a new message.
  logic [BEAT_CNT_W-1:0] r_left;
  logic [BEAT_CNT_W-1:0] w_beats;

  assign w_beats = tl_num_beats(i_opcode, i_size, BEAT_LG, D_CHAN);
  assign o_first = (r_left == '0);
  assign o_last  = o_first ? (w_beats == BEAT_CNT_W'(1)) : (r_left == BEAT_CNT_W'(1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_left <= '0;
    else if (i_fire)
      r_left <= o_first ? (w_beats - BEAT_CNT_W'(1)) : (r_left - BEAT_CNT_W'(1));
  end

endmodule

// File: rtl/tl_ul_client_arbiter.sv
// Shares one TileLink-UL client port between two requesters.
//   clock, reset : sole clock; asynchronous active-low reset
//   in0, in1     : requester links (source SRC_W bits), arbiter is the slave
//   out          : shared downstream link (source SRC_W+1 bits), arbiter is
//                  the master; source MSB carries the requester index
// A: round-robin with burst lock and a per-requester in-flight limit,
//    zero-cycle combinational grant.
// D: routed back by source MSB, MSB stripped.
module tl_ul_client_arbiter
  import tl_ul_pkg::*;
#(
  parameter int SRC_W    = 2,
  parameter int MAX_INFL = 4,
  parameter int BEAT_LG  = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_ul_client_arbiter_if.slave  in0,
  tl_ul_client_arbiter_if.slave  in1,
  tl_ul_client_arbiter_if.master out
);

  localparam int                INFL_W = 4;
  localparam logic [INFL_W-1:0] MAX_C  = INFL_W'(MAX_INFL);

  lock_state_e             r_state, w_state_nxt;
  logic                    r_lock_id, w_lock_id_nxt;
  logic                    r_rr_ptr, w_rr_ptr_nxt;
  logic [1:0][INFL_W-1:0]  r_infl;

  logic [1:0]  w_elig, w_inc, w_dec;
  logic        w_sel, w_grant;
  logic        w_a_fire, w_a_first, w_a_last;
  logic        w_d_tgt, w_d_fire, w_d_first, w_d_last;

  logic [2:0]       w_a_opcode, w_a_param, w_a_size;
  logic [SRC_W-1:0] w_a_source;
  logic [31:0]      w_a_address, w_a_data;
  logic [3:0]       w_a_mask;
  logic             w_a_corrupt;

  // The in-flight limit gates only new messages; burst continuation beats
  // bypass it through the LOCKED branch below.
  assign w_elig[0] = in0.a_valid & (r_infl[0] < MAX_C);
  assign w_elig[1] = in1.a_valid & (r_infl[1] < MAX_C);

  always_comb begin
    w_sel   = r_rr_ptr;
    w_grant = 1'b0;
    if (r_state == LOCKED) begin
      w_sel   = r_lock_id;
      w_grant = r_lock_id ? in1.a_valid : in0.a_valid;
    end else if (&w_elig) begin
      w_sel   = r_rr_ptr;
      w_grant = 1'b1;
    end else if (w_elig[0]) begin
      w_sel   = 1'b0;
      w_grant = 1'b1;
    end else if (w_elig[1]) begin
      w_sel   = 1'b1;
      w_grant = 1'b1;
    end
  end

  always_comb begin
    w_a_opcode  = in0.a_opcode;
    w_a_param   = in0.a_param;
    w_a_size    = in0.a_size;
    w_a_source  = in0.a_source;
    w_a_address = in0.a_address;
    w_a_mask    = in0.a_mask;
    w_a_data    = in0.a_data;
    w_a_corrupt = in0.a_corrupt;
    if (w_sel) begin
      w_a_opcode  = in1.a_opcode;
      w_a_param   = in1.a_param;
      w_a_size    = in1.a_size;
      w_a_source  = in1.a_source;
      w_a_address = in1.a_address;
      w_a_mask    = in1.a_mask;
      w_a_data    = in1.a_data;
      w_a_corrupt = in1.a_corrupt;
    end
  end

  // Handshakes are forced low while reset is held, even though the
  // upstream/downstream valids may still be toggling.
  assign out.a_valid   = reset & w_grant;
  assign out.a_opcode  = w_a_opcode;
  assign out.a_param   = w_a_param;
  assign out.a_size    = w_a_size;
  assign out.a_source  = {w_sel, w_a_source};
  assign out.a_address = w_a_address;
  assign out.a_mask    = w_a_mask;
  assign out.a_data    = w_a_data;
  assign out.a_corrupt = w_a_corrupt;
  assign in0.a_ready   = reset & w_grant & ~w_sel & out.a_ready;
  assign in1.a_ready   = reset & w_grant &  w_sel & out.a_ready;
  assign w_a_fire      = out.a_valid & out.a_ready;

  tl_beat_counter #(.BEAT_LG(BEAT_LG), .D_CHAN(1'b0)) u_a_beats (
    .clock    (clock),
    .reset    (reset),
    .i_fire   (w_a_fire),
    .i_opcode (w_a_opcode),
    .i_size   (w_a_size),
    .o_first  (w_a_first),
    .o_last   (w_a_last)
  );

  // Lock FSM: a multi-beat first beat pins the grant to its owner until the
  // last beat; the round-robin pointer moves only when a message completes.
  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    w_rr_ptr_nxt  = r_rr_ptr;
    case (r_state)
      UNLOCKED: begin
        if (w_a_fire) begin
          if (!w_a_last) begin
            w_state_nxt   = LOCKED;
            w_lock_id_nxt = w_sel;
          end else begin
            w_rr_ptr_nxt  = ~w_sel;
          end
        end
      end
      LOCKED: begin
        if (w_a_fire && w_a_last) begin
          w_state_nxt  = UNLOCKED;
          w_rr_ptr_nxt = ~r_lock_id;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= UNLOCKED;
      r_lock_id <= 1'b0;
      r_rr_ptr  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
    end
  end

  assign w_d_tgt       = out.d_source[SRC_W];
  assign out.d_ready   = reset & (w_d_tgt ? in1.d_ready : in0.d_ready);
  assign w_d_fire      = out.d_valid & out.d_ready;
  assign in0.d_valid   = reset & out.d_valid & ~w_d_tgt;
  assign in1.d_valid   = reset & out.d_valid &  w_d_tgt;
  assign in0.d_opcode  = out.d_opcode;
  assign in1.d_opcode  = out.d_opcode;
  assign in0.d_size    = out.d_size;
  assign in1.d_size    = out.d_size;
  assign in0.d_source  = out.d_source[SRC_W-1:0];
  assign in1.d_source  = out.d_source[SRC_W-1:0];
  assign in0.d_denied  = out.d_denied;
  assign in1.d_denied  = out.d_denied;
  assign in0.d_data    = out.d_data;
  assign in1.d_data    = out.d_data;
  assign in0.d_corrupt = out.d_corrupt;
  assign in1.d_corrupt = out.d_corrupt;

  tl_beat_counter #(.BEAT_LG(BEAT_LG), .D_CHAN(1'b1)) u_d_beats (
    .clock    (clock),
    .reset    (reset),
    .i_fire   (w_d_fire),
    .i_opcode (out.d_opcode),
    .i_size   (out.d_size),
    .o_first  (w_d_first),
    .o_last   (w_d_last)
  );

  // A message is outstanding from its first A beat to its last D beat.
  assign w_inc = {w_a_fire & w_a_first & w_sel, w_a_fire & w_a_first & ~w_sel};
  assign w_dec = {w_d_fire & w_d_last & w_d_tgt, w_d_fire & w_d_last & ~w_d_tgt};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_infl <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_inc[i] && !w_dec[i] && (r_infl[i] < MAX_C))
          r_infl[i] <= r_infl[i] + INFL_W'(1);
        else if (w_dec[i] && !w_inc[i] && (r_infl[i] != '0))
          r_infl[i] <= r_infl[i] - INFL_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  // A response to a requester with nothing outstanding is a protocol error;
  // the counter saturates at zero instead of wrapping.
  a_no_orphan_d: assert property (@(posedge clock) disable iff (!reset)
    (w_d_fire && w_d_first) |->
      ((r_infl[w_d_tgt] != '0) || w_inc[w_d_tgt]));
`endif

endmodule

// File: tb/tb_tl_ul_client_arbiter.sv
module tb_tl_ul_client_arbiter;
  import tl_ul_pkg::*;

  localparam int SRC_W    = 2;
  localparam int MAX_INFL = 4;
  localparam int BEAT_LG  = 2;
  localparam int N_CYC    = 3000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tl_ul_client_arbiter_if #(.SW(SRC_W))   in0_if ();
  tl_ul_client_arbiter_if #(.SW(SRC_W))   in1_if ();
  tl_ul_client_arbiter_if #(.SW(SRC_W+1)) out_if ();

  tl_ul_client_arbiter #(
    .SRC_W    (SRC_W),
    .MAX_INFL (MAX_INFL),
    .BEAT_LG  (BEAT_LG)
  ) dut (
    .clock (clock),
    .reset (reset),
    .in0   (in0_if),
    .in1   (in1_if),
    .out   (out_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Beats in a message, straight from the protocol rule.
  function automatic int beats_of(input logic [2:0] op, input logic [2:0] sz, input bit is_d);
    bit carries_data;
    carries_data = is_d ? (op == 3'd1) : (op <= 3'd3);
    if (carries_data && int'(sz) > BEAT_LG) return 2 ** (int'(sz) - BEAT_LG);
    return 1;
  endfunction

  // Requester-side message currently being offered
  logic [2:0]       rq_op   [2];
  logic [2:0]       rq_size [2];
  logic [SRC_W-1:0] rq_src  [2];
  logic [31:0]      rq_addr [2];
  int               rq_beats[2];
  int               rq_done [2];
  // Per-cycle drive values
  logic             drv_av  [2];
  logic [31:0]      drv_data[2];
  logic [3:0]       drv_mask[2];
  logic             drv_dr  [2];
  logic             drv_oar;

  // Reference model state
  bit m_locked;
  int m_owner, m_left, m_rr;
  int m_infl[2];

  // Response generator state
  bit               d_act;
  int               d_tgt, d_beats, d_done;
  logic [2:0]       d_op, d_size;
  logic [SRC_W-1:0] d_src;

  task automatic new_req(input int i, input bit gets_only);
    if (gets_only || $urandom_range(0, 2) == 0) rq_op[i] = GET;
    else rq_op[i] = 3'($urandom_range(0, 3));
    rq_size[i]  = 3'($urandom_range(0, 4));
    rq_src[i]   = SRC_W'($urandom);
    rq_addr[i]  = $urandom;
    rq_beats[i] = beats_of(rq_op[i], rq_size[i], 1'b0);
    rq_done[i]  = 0;
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_left = 0; m_rr = 0;
    m_infl[0] = 0; m_infl[1] = 0;
    d_act = 0;
    new_req(0, 1'b0);
    new_req(1, 1'b0);
  endtask

  task automatic apply_drive();
    in0_if.a_valid   = drv_av[0];
    in0_if.a_opcode  = rq_op[0];
    in0_if.a_param   = 3'($urandom);
    in0_if.a_size    = rq_size[0];
    in0_if.a_source  = rq_src[0];
    in0_if.a_address = rq_addr[0];
    in0_if.a_mask    = drv_mask[0];
    in0_if.a_data    = drv_data[0];
    in0_if.a_corrupt = 1'b0;
    in0_if.d_ready   = drv_dr[0];
    in1_if.a_valid   = drv_av[1];
    in1_if.a_opcode  = rq_op[1];
    in1_if.a_param   = 3'($urandom);
    in1_if.a_size    = rq_size[1];
    in1_if.a_source  = rq_src[1];
    in1_if.a_address = rq_addr[1];
    in1_if.a_mask    = drv_mask[1];
    in1_if.a_data    = drv_data[1];
    in1_if.a_corrupt = 1'b0;
    in1_if.d_ready   = drv_dr[1];
    out_if.a_ready   = drv_oar;
  endtask

  initial begin
    bit phase0, in_rst;
    bit exp_vld;
    int exp_sel;
    logic [63:0] exp_src;

    model_reset();
    for (int i = 0; i < 2; i++) begin
      drv_av[i] = 0; drv_data[i] = '0; drv_mask[i] = '0; drv_dr[i] = 0;
    end
    drv_oar = 0;
    apply_drive();
    out_if.d_valid = 0; out_if.d_opcode = '0; out_if.d_size = '0; out_if.d_source = '0;
    out_if.d_denied = 0; out_if.d_data = '0; out_if.d_corrupt = 0;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clock);
      #1;
      phase0 = (cyc >= 3 && cyc < 43);
      in_rst = (cyc < 3) || (cyc >= 43 && $urandom_range(0, 199) == 0);
      if (in_rst) begin
        reset = 1'b0;
        model_reset();
      end else begin
        if (!reset) model_reset();
        reset = 1'b1;
      end
      if (cyc == 3) begin
        new_req(0, 1'b1);
        new_req(1, 1'b1);
      end

      for (int i = 0; i < 2; i++) begin
        drv_av[i]   = phase0 ? 1'b1 : ($urandom_range(0, 3) != 0);
        drv_data[i] = $urandom;
        drv_mask[i] = 4'($urandom);
        drv_dr[i]   = ($urandom_range(0, 3) != 0);
      end
      drv_oar = phase0 ? 1'b1 : ($urandom_range(0, 4) != 0);
      apply_drive();

      // Start a response only for a requester with something outstanding
      if (!in_rst && !phase0 && !d_act && $urandom_range(0, 3) == 0 &&
          (m_infl[0] > 0 || m_infl[1] > 0)) begin
        if (m_infl[0] > 0 && m_infl[1] > 0) d_tgt = int'($urandom_range(0, 1));
        else d_tgt = (m_infl[0] > 0) ? 0 : 1;
        d_op    = ($urandom_range(0, 2) == 0) ? ACK : ACK_DATA;
        d_size  = 3'($urandom_range(2, 4));
        d_src   = SRC_W'($urandom);
        d_beats = beats_of(d_op, d_size, 1'b1);
        d_done  = 0;
        d_act   = 1;
      end
      out_if.d_valid   = in_rst ? 1'($urandom) : d_act;
      out_if.d_opcode  = d_op;
      out_if.d_size    = d_size;
      out_if.d_source  = in_rst ? 3'($urandom) : {1'(d_tgt), d_src};
      out_if.d_denied  = 1'($urandom);
      out_if.d_data    = $urandom;
      out_if.d_corrupt = 1'b0;

      #3;
      if (in_rst) begin
        check_val("rst_out_a_valid", 64'(out_if.a_valid), 64'd0);
        check_val("rst_in0_a_ready", 64'(in0_if.a_ready), 64'd0);
        check_val("rst_in1_a_ready", 64'(in1_if.a_ready), 64'd0);
        check_val("rst_out_d_ready", 64'(out_if.d_ready), 64'd0);
        check_val("rst_in0_d_valid", 64'(in0_if.d_valid), 64'd0);
        check_val("rst_in1_d_valid", 64'(in1_if.d_valid), 64'd0);
        continue;
      end

      // Expected grant: a locked burst owns the port; otherwise try the
      // round-robin favourite first, then the other, skipping anyone at
      // the in-flight limit.
      exp_vld = 0;
      exp_sel = 0;
      if (m_locked) begin
        exp_sel = m_owner;
        exp_vld = drv_av[m_owner];
      end else begin
        int order[2];
        order[0] = m_rr;
        order[1] = 1 - m_rr;
        foreach (order[k])
          if (!exp_vld && drv_av[order[k]] && m_infl[order[k]] < MAX_INFL) begin
            exp_vld = 1;
            exp_sel = order[k];
          end
      end

      check_val("out_a_valid", 64'(out_if.a_valid), 64'(exp_vld));
      check_val("in0_a_ready", 64'(in0_if.a_ready), 64'(exp_vld && exp_sel == 0 && drv_oar));
      check_val("in1_a_ready", 64'(in1_if.a_ready), 64'(exp_vld && exp_sel == 1 && drv_oar));
      if (exp_vld) begin
        exp_src = 64'((exp_sel << SRC_W) | int'(rq_src[exp_sel]));
        check_val("out_a_source",  64'(out_if.a_source),  exp_src);
        check_val("out_a_data",    64'(out_if.a_data),    64'(drv_data[exp_sel]));
        check_val("out_a_mask",    64'(out_if.a_mask),    64'(drv_mask[exp_sel]));
        check_val("out_a_address", 64'(out_if.a_address), 64'(rq_addr[exp_sel]));
        check_val("out_a_opcode",  64'(out_if.a_opcode),  64'(rq_op[exp_sel]));
      end

      check_val("in0_d_valid", 64'(in0_if.d_valid), 64'(d_act && d_tgt == 0));
      check_val("in1_d_valid", 64'(in1_if.d_valid), 64'(d_act && d_tgt == 1));
      if (d_act) begin
        check_val("out_d_ready", 64'(out_if.d_ready), 64'(drv_dr[d_tgt]));
        if (d_tgt == 0) begin
          check_val("in0_d_source", 64'(in0_if.d_source), 64'(d_src));
          check_val("in0_d_data",   64'(in0_if.d_data),   64'(out_if.d_data));
        end else begin
          check_val("in1_d_source", 64'(in1_if.d_source), 64'(d_src));
          check_val("in1_d_data",   64'(in1_if.d_data),   64'(out_if.d_data));
        end
      end

      // Advance the model by what transfers at the coming edge
      if (exp_vld && drv_oar) begin
        if (rq_done[exp_sel] == 0) m_infl[exp_sel]++;
        if (m_locked) begin
          m_left--;
          if (m_left == 0) begin
            m_locked = 0;
            m_rr = 1 - m_owner;
          end
        end else if (rq_beats[exp_sel] > 1) begin
          m_locked = 1;
          m_owner  = exp_sel;
          m_left   = rq_beats[exp_sel] - 1;
        end else begin
          m_rr = 1 - exp_sel;
        end
        rq_done[exp_sel]++;
        if (rq_done[exp_sel] == rq_beats[exp_sel]) new_req(exp_sel, phase0);
      end
      if (d_act && drv_dr[d_tgt]) begin
        d_done++;
        if (d_done == d_beats) begin
          m_infl[d_tgt]--;
          d_act = 0;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
